// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 7-register pipeline, including exception/eret entry sequencing.
// Define STALL_PERF_EN to build the stall_cycles / exc_count performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned EXC_HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_busy,
    input  logic        load_use,
    input  logic        div_busy,
    input  logic        dcache_busy,
    input  logic        exc_req,
    input  logic        exc_is_eret,
    output logic        pc_wr,
    output logic        pf_if_wr,
    output logic        if_id_wr,
    output logic        id_ex_wr,
    output logic        ex_mem1_wr,
    output logic        mem1_mem2_wr,
    output logic        mem2_wb_wr,
    output logic        pf_if_flush,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem1_flush,
    output logic        mem1_mem2_flush,
    output logic        mem2_wb_flush,
    output logic        redirect_valid,
    output logic        redirect_eret,
    output logic        drain_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] exc_count
);

    typedef enum logic [1:0] {RUN, DRAIN, FLUSH, IC_WAIT} state_e;

    // Register positions along the pipe; PC is 0 and has no flush strobe, so 0 also means "no bubble".
    localparam logic [2:0] IDX_NONE      = 3'd0;
    localparam logic [2:0] IDX_IF_ID     = 3'd2;
    localparam logic [2:0] IDX_ID_EX     = 3'd3;
    localparam logic [2:0] IDX_EX_MEM1   = 3'd4;
    localparam logic [2:0] IDX_MEM1_MEM2 = 3'd5;
    localparam logic [2:0] IDX_MEM2_WB   = 3'd6;

    state_e      state_q, state_d;
    logic        eret_q, eret_d;
    logic [31:0] drain_cnt_q, drain_cnt_d;
    logic [2:0]  bubble;
    logic [6:0]  wr;
    logic [6:1]  fl;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d        = state_q;
        eret_d         = eret_q;
        drain_cnt_d    = '0;
        bubble         = IDX_NONE;
        wr             = '1;
        fl             = '0;
        redirect_valid = 1'b0;
        redirect_eret  = 1'b0;
        drain_timeout  = 1'b0;

        unique case (state_q)
            RUN: begin
                if (exc_req) begin
                    eret_d = exc_is_eret;
                    if (dcache_busy) begin
                        bubble  = IDX_MEM2_WB;
                        state_d = DRAIN;
                    end else begin
                        bubble  = IDX_MEM1_MEM2;
                        state_d = FLUSH;
                    end
                end else if (dcache_busy) bubble = IDX_MEM2_WB;
                else if (div_busy)        bubble = IDX_EX_MEM1;
                else if (load_use)        bubble = IDX_ID_EX;
                else if (icache_busy)     bubble = IDX_IF_ID;
            end
            DRAIN: begin
                // Saturating so the timeout pulse fires once per drain episode.
                drain_cnt_d   = (drain_cnt_q == EXC_HOLD_MAX) ? drain_cnt_q : drain_cnt_q + 32'd1;
                drain_timeout = (drain_cnt_q == EXC_HOLD_MAX - 1);
                if (dcache_busy) begin
                    bubble = IDX_MEM2_WB;
                end else begin
                    bubble  = IDX_MEM1_MEM2;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                wr             = 7'b1000001;
                fl             = 6'b011111;
                redirect_valid = 1'b1;
                redirect_eret  = eret_q;
                state_d        = icache_busy ? IC_WAIT : RUN;
            end
            IC_WAIT: begin
                wr = 7'b1111000;
                fl = 6'b000011;
                if (!icache_busy) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        // Held upstream of the bubble, bubble register flushed, downstream keeps flowing.
        if (bubble != IDX_NONE) begin
            for (int i = 0; i < 7; i++) wr[i] = (i > int'(bubble));
            for (int i = 1; i < 7; i++) fl[i] = (i == int'(bubble));
        end

        if (!rst) begin
            wr             = '0;
            fl             = '1;
            redirect_valid = 1'b0;
            redirect_eret  = 1'b0;
            drain_timeout  = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            eret_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            eret_q      <= eret_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign pc_wr           = wr[0];
    assign pf_if_wr        = wr[1];
    assign if_id_wr        = wr[2];
    assign id_ex_wr        = wr[3];
    assign ex_mem1_wr      = wr[4];
    assign mem1_mem2_wr    = wr[5];
    assign mem2_wb_wr      = wr[6];
    assign pf_if_flush     = fl[1];
    assign if_id_flush     = fl[2];
    assign id_ex_flush     = fl[3];
    assign ex_mem1_flush   = fl[4];
    assign mem1_mem2_flush = fl[5];
    assign mem2_wb_flush   = fl[6];

`ifdef STALL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] exc_count_q, exc_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + 32'(!wr[0]);
        exc_count_d    = exc_count_q + 32'(state_q == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            exc_count_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            exc_count_q    <= exc_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign exc_count    = exc_count_q;
`else
    assign stall_cycles = '0;
    assign exc_count    = '0;
`endif

endmodule
